// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type, default cache geometry and address-width helper
//   cache_state_e : controller states
//   DEF_*         : default geometry matching the cache_memory datapath
//   cache_geom()  : derives tag/index/offset widths from the geometry
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    WRITE_BACK,
    ALLOCATE,
    REFILL,
    RESPOND
  } cache_state_e;

  localparam int ADDR_WIDTH          = 32;
  localparam int DEF_WORD_SIZE       = 32;
  localparam int DEF_WORDS_PER_BLOCK = 4;
  localparam int DEF_NUM_BLOCKS      = 64;
  localparam int DEF_NUM_WAYS        = 4;

  typedef struct packed {
    int tag_w;
    int index_w;
    int offset_w;
  } cache_geom_t;

  // index selects one of NUM_BLOCKS/NUM_WAYS sets, offset one word of a line,
  // and the tag takes whatever is left of the 32-bit word address
  function automatic cache_geom_t cache_geom(int blocks, int ways, int words);
    cache_geom_t g;
    g.index_w  = $clog2(blocks / ways);
    g.offset_w = $clog2(words);
    g.tag_w    = ADDR_WIDTH - g.index_w - g.offset_w;
    return g;
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: single-request sequencer for the cache_memory set-associative datapath
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cpu_req_*/cpu_addr/cpu_wdata    CPU request (valid/ready handshake), cpu_rdata + cpu_resp_valid response
//   tag/index/blk_offset/req_type   registered request fields to the datapath
//   read/write_en_cache/mem,data_in datapath enables and store data
//   hit/dirty_bit/data_out/victim_tag  datapath lookup results
//   mem_req_valid/we/mem_addr/mem_ready  block-level memory transaction (write-back or refill)
//   hit_cnt/miss_cnt/wb_cnt         performance counters, present only with PERF_CNT_EN defined
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int WORD_SIZE       = DEF_WORD_SIZE,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int NUM_BLOCKS      = DEF_NUM_BLOCKS,
  parameter int NUM_WAYS        = DEF_NUM_WAYS,
  localparam cache_geom_t GEOM  = cache_geom(NUM_BLOCKS, NUM_WAYS, WORDS_PER_BLOCK),
  localparam int INDEX_WIDTH    = GEOM.index_w,
  localparam int OFFSET_WIDTH   = GEOM.offset_w,
  localparam int TAG_WIDTH      = GEOM.tag_w
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic                    cpu_req_type,
  input  logic [WORD_SIZE-1:0]    cpu_wdata,
  output logic [WORD_SIZE-1:0]    cpu_rdata,
  output logic                    cpu_resp_valid,
  output logic [TAG_WIDTH-1:0]    tag,
  output logic [INDEX_WIDTH-1:0]  index,
  output logic [OFFSET_WIDTH-1:0] blk_offset,
  output logic                    req_type,
  output logic                    read_en_cache,
  output logic                    write_en_cache,
  output logic                    read_en_mem,
  output logic                    write_en_mem,
  output logic [WORD_SIZE-1:0]    data_in,
  input  logic                    hit,
  input  logic                    dirty_bit,
  input  logic [WORD_SIZE-1:0]    data_out,
  input  logic [TAG_WIDTH-1:0]    victim_tag,
  output logic                    mem_req_valid,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_ready
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt,
  output logic [31:0]             wb_cnt
`endif
);

  cache_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  type_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic [TAG_WIDTH-1:0]  victim_q;
  logic                  replay_q;
  logic                  hit_write;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // victim_tag is captured on a dirty miss so the write-back address cannot
  // move while the memory transaction is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      type_q   <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      victim_q <= '0;
      replay_q <= 1'b0;
    end else begin
      if (state_q == IDLE && cpu_req_valid) begin
        addr_q   <= cpu_addr;
        type_q   <= cpu_req_type;
        wdata_q  <= cpu_wdata;
        replay_q <= 1'b0;
      end
      if (state_q == COMPARE && hit && !type_q) rdata_q <= data_out;
      if (state_q == COMPARE && !hit && dirty_bit) victim_q <= victim_tag;
      if (state_q == REFILL) replay_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = cpu_req_valid ? LOOKUP : IDLE;
      LOOKUP:     state_d = COMPARE;
      COMPARE:    state_d = hit ? RESPOND : dirty_bit ? WRITE_BACK : ALLOCATE;
      WRITE_BACK: state_d = mem_ready ? ALLOCATE : WRITE_BACK;
      ALLOCATE:   state_d = mem_ready ? REFILL : ALLOCATE;
      REFILL:     state_d = LOOKUP;
      RESPOND:    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  assign tag        = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign index      = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign blk_offset = addr_q[OFFSET_WIDTH-1:0];
  assign req_type   = type_q;
  assign cpu_rdata  = rdata_q;
  assign hit_write  = state_q == COMPARE && hit && type_q;

  always_comb begin
    cpu_req_ready  = state_q == IDLE;
    cpu_resp_valid = state_q == RESPOND;
    read_en_cache  = state_q == LOOKUP || state_q == COMPARE;
    write_en_cache = hit_write || state_q == REFILL;
    read_en_mem    = state_q == REFILL;
    write_en_mem   = state_q == WRITE_BACK;
    mem_req_valid  = state_q == WRITE_BACK || state_q == ALLOCATE;
    mem_req_we     = state_q == WRITE_BACK;
    data_in        = hit_write ? wdata_q : '0;
    mem_addr       = !mem_req_valid ? '0 :
                     {(mem_req_we ? victim_q : tag), index, {OFFSET_WIDTH{1'b0}}};
  end

`ifdef PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  // only the first COMPARE of a request counts; the post-refill replay is skipped
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == COMPARE && !replay_q && hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (state_q == COMPARE && !replay_q && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == WRITE_BACK && mem_ready)      wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: doc/cache_ctrl_fsm.md
# cache_ctrl_fsm

Sequencing controller for the `cache_memory` set-associative datapath. Accepts one CPU load/store at a time, splits the address into tag/index/offset, and drives the datapath enables through lookup, write-back of a dirty victim, refill from memory, and replay. It sits between the CPU request port and the memory port, replacing hand-sequenced enables with a single FSM.

## Interface
Parameters:
- WORD_SIZE, 32, bits per word
- WORDS_PER_BLOCK, 4, words per line
- NUM_BLOCKS, 64, total lines
- NUM_WAYS, 4, associativity; NUM_SETS = NUM_BLOCKS/NUM_WAYS
- INDEX_WIDTH, OFFSET_WIDTH and TAG_WIDTH are derived exactly as in `cache_memory`; TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH.

Ports:
- Clocking (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  controller can accept a request
- cpu_addr  in  32  word address {tag,index,offset}
- cpu_req_type  in  1  0 = read, 1 = write
- cpu_wdata  in  WORD_SIZE  store data
- cpu_rdata  out  WORD_SIZE  load data
- cpu_resp_valid  out  1  one-cycle completion pulse
- tag / index / blk_offset / req_type  out  TAG_WIDTH / INDEX_WIDTH / OFFSET_WIDTH / 1  to datapath
- read_en_cache, write_en_cache, read_en_mem, write_en_mem  out  1 each  datapath enables
- data_in  out  WORD_SIZE  to datapath
- hit, dirty_bit  in  1 each  from datapath
- data_out  in  WORD_SIZE  from datapath
- victim_tag  in  TAG_WIDTH  tag of the selected victim way, from datapath
- mem_req_valid  out  1  memory transaction active
- mem_req_we  out  1  1 = write-back, 0 = refill
- mem_addr  out  32  block-aligned address; offset bits are 0
- mem_ready  in  1  memory completes the transaction this cycle

## Operation
- States: IDLE, LOOKUP, COMPARE, WRITE_BACK, ALLOCATE, REFILL, RESPOND.
- IDLE: cpu_req_ready = 1. On valid&ready, register addr, type and wdata, then go to LOOKUP. The datapath outputs come only from these registers.
- LOOKUP: read_en_cache = 1 and req_type = registered type. Go to COMPARE.
- COMPARE: read_en_cache stays 1. The controller samples hit and dirty_bit.
  - Hit, read: latch data_out into cpu_rdata, go to RESPOND.
  - Hit, write: write_en_cache = 1 and data_in = wdata for this cycle, go to RESPOND.
  - Miss, dirty_bit = 0: go to ALLOCATE.
  - Miss, dirty_bit = 1: go to WRITE_BACK.
- WRITE_BACK: mem_req_valid = 1, mem_req_we = 1, write_en_mem = 1, mem_addr = {victim_tag, index, 0}. Hold until mem_ready, then go to ALLOCATE.
- ALLOCATE: mem_req_valid = 1, mem_req_we = 0, mem_addr = {tag, index, 0}. Hold until mem_ready, then go to REFILL.
- REFILL: read_en_mem = 1 and write_en_cache = 1 for exactly one cycle, then go to LOOKUP (replay). A replay always hits.
- RESPOND: cpu_resp_valid = 1 for one cycle, then go to IDLE. cpu_rdata holds its value until the next read response.
- mem_ready is ignored whenever mem_req_valid = 0. mem_ready in the first cycle of mem_req_valid completes the transaction.
- mem_addr and mem_req_we stay stable while mem_req_valid = 1.

## Timing
- Reset: state = IDLE. Every output is 0 except cpu_req_ready, which is 1. Registered addr, type and wdata are cleared.
- Reset mid-operation: abandon the transaction immediately and drop mem_req_valid next cycle. No response is issued.
- Read hit: accept at cycle 0, LOOKUP at 1, COMPARE at 2, cpu_resp_valid at 3.
- Write hit: write_en_cache is asserted in cycle 2, response at cycle 3.
- Clean miss: 3 + M + 1 (REFILL) + 3 cycles, where M = cycles mem_req_valid is held.
- Dirty miss: adds W write-back cycles to the clean-miss latency.
- Back-to-back: a new request is accepted in the cycle after RESPOND, so the minimum spacing is 4 cycles.

## Configuration
- PERF_CNT_EN defined: adds outputs hit_cnt, miss_cnt and wb_cnt, each 32 bits, wrapping, reset to 0.
  - hit_cnt increments on a COMPARE hit of the first lookup only; replays are not counted.
  - miss_cnt increments on each initial miss.
  - wb_cnt increments on WRITE_BACK completion.
- PERF_CNT_EN undefined: these ports and counters do not exist.

## Structure
- Package `cache_pkg`:
  - the state enum `cache_state_e`
  - default geometry localparams
  - a function computing TAG, INDEX and OFFSET widths
- The counters live inline under the macro. No sub-module; the FSM is a single module.

## Test plan
- Preload set 0 way 0 with {tag 1ABCDE, dirty, line AAAABBBB_CCCC1111_DDDD2222_EEEE3333}. Read with offset 2 -> resp at cycle 3, cpu_rdata = CCCC1111, no mem_req_valid.
- Write hit to set 0 way 1 (tag 2BCDEF), offset 0, wdata 0BADF00D -> write_en_cache pulses once in cycle 2. A following read returns 0BADF00D.
- Clean miss, tag 333333, set 1 (ways 0 and 2 valid) -> ALLOCATE with mem_addr = {333333,1,0}. Refill with CAFEBABE_FEEDFACE_DEADBEAF_87654321 and mem_ready after 3 cycles -> offset 0 read returns 87654321, no write_en_mem.
- Dirty miss in full set 0, tag 1EEEEF -> WRITE_BACK first with mem_addr = {victim_tag,0,0} and write_en_mem held until mem_ready, then ALLOCATE, then the response.
- Assert rst during ALLOCATE -> next cycle mem_req_valid = 0, cpu_req_ready = 1, no cpu_resp_valid.
- PERF_CNT_EN: run the sequence hit, clean miss, dirty miss -> hit_cnt = 1, miss_cnt = 2, wb_cnt = 1.
